// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V core front end: data width, fetch FSM
// encoding and the end-of-program instruction words.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] ECALL_WORD  = 32'h0000_0073;
   localparam logic [XLEN-1:0] EBREAK_WORD = 32'h0010_0073;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response watchdog for the fetch stage: loaded with TIMEOUT on clr, counts
// down while en is high, and reports expired on the last permitted wait cycle.
module fetch_timeout_ctr #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = W'(TIMEOUT);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Deliberately not qualified by en so the FSM can use it without a comb loop.
   assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid transaction to
// instruction memory, valid/ready hold toward decode, sticky finish and fault.
module instr_fetch #(
   parameter int unsigned TIMEOUT     = 15,
   parameter logic [31:0] ECALL_WORD  = rv_pkg::ECALL_WORD,
   parameter logic [31:0] EBREAK_WORD = rv_pkg::EBREAK_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        pc_valid,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        finish_flag,
   output logic        fault
);

   import rv_pkg::*;

   fetch_state_t state_q, state_d;
   logic [31:0]  imem_addr_q, imem_addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic         imem_req_q, imem_req_d;
   logic         instr_valid_q, instr_valid_d;
   logic         finish_q, finish_d;
   logic         fault_q, fault_d;
   logic         drop_q, drop_d;

   logic ctr_clr;
   logic ctr_en;
   logic ctr_expired;
   logic accept;
   logic rdata_is_finish;

   fetch_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (ctr_clr),
      .en      (ctr_en),
      .expired (ctr_expired)
   );

   assign accept          = pc_valid && !flush && !finish_q && !fault_q;
   assign rdata_is_finish = (imem_rdata == ECALL_WORD) || (imem_rdata == EBREAK_WORD);

   always_comb begin
      // NOTE: every value written here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      imem_addr_d = imem_addr_q;
      instr_d     = instr_q;
      instr_pc_d  = instr_pc_q;
      finish_d    = finish_q;
      fault_d     = fault_q;
      drop_d      = drop_q;
      ctr_clr     = 1'b0;
      ctr_en      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (pc[1:0] != 2'b00) begin
                  fault_d = 1'b1;
               end else begin
                  imem_addr_d = pc;
                  state_d     = REQ;
               end
            end
         end
         REQ: begin
            // A grant in the flush cycle still produces a response, which must be swallowed later.
            if (flush) begin
               state_d = IDLE;
               if (imem_gnt) drop_d = 1'b1;
            end else if (imem_gnt) begin
               state_d = WAIT;
               ctr_clr = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  instr_d    = imem_rdata;
                  instr_pc_d = imem_addr_q;
                  state_d    = HOLD;
                  if (rdata_is_finish) finish_d = 1'b1;
               end
            end else begin
               ctr_en = 1'b1;
               if (flush) drop_d = 1'b1;
               if (ctr_expired) begin
                  fault_d = 1'b1;
                  drop_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         HOLD: begin
            if (flush || instr_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      imem_req_d    = (state_d == REQ);
      instr_valid_d = (state_d == HOLD);
   end

   // NOTE: the asynchronous reset clears every flop here, including the data registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         imem_addr_q   <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         finish_q      <= 1'b0;
         fault_q       <= 1'b0;
         drop_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         imem_addr_q   <= imem_addr_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         imem_req_q    <= imem_req_d;
         instr_valid_q <= instr_valid_d;
         finish_q      <= finish_d;
         fault_q       <= fault_d;
         drop_q        <= drop_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign finish_flag = finish_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed and randomized fetches with a
// queue-based scoreboard and an independent monitor on the decode interface.
module tb_instr_fetch;

   import rv_pkg::*;

   localparam int TIMEOUT = 15;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        pc_valid;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        finish_flag;
   logic        fault;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        fin;
   } exp_t;

   exp_t exp_q[$];
   logic finish_seen;
   int   vectors;
   int   miscompares;

   instr_fetch #(
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .finish_flag (finish_flag),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: pops one expectation per valid window and holds it for stability checks.
   initial begin
      exp_t cur;
      logic prev_valid;
      prev_valid = 1'b0;
      cur.instr = '0;
      cur.pc    = '0;
      cur.fin   = 1'b0;
      forever begin
         @(negedge clk);
         if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_valid: instr %h pc %h with no fetch outstanding", instr, instr_pc);
            end else begin
               cur = exp_q.pop_front();
               check("instr", instr, cur.instr);
               check("instr_pc", instr_pc, cur.pc);
               check("finish_with_valid", {31'b0, finish_flag}, {31'b0, cur.fin});
            end
         end else if (instr_valid) begin
            check("instr_stable", instr, cur.instr);
            check("instr_pc_stable", instr_pc, cur.pc);
         end
         prev_valid = instr_valid;
      end
   end

   // hold_mode: 0 = ready handshake, 1 = flush in HOLD, 2 = leave DUT in HOLD.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int gnt_dly,
                           input int rv_dly, input int rdy_dly, input int hold_mode);
      exp_t e;
      pc = addr;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      pc = $urandom();
      check("req_assert", {31'b0, imem_req}, 32'd1);
      check("req_addr", imem_addr, addr);
      repeat (gnt_dly) begin
         tick();
         check("req_held", {31'b0, imem_req}, 32'd1);
      end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      check("req_after_gnt", {31'b0, imem_req}, 32'd0);
      repeat (rv_dly) begin
         imem_rdata = $urandom();
         tick();
         check("no_early_valid", {31'b0, instr_valid}, 32'd0);
      end
      check("finish_before_capture", {31'b0, finish_flag}, {31'b0, finish_seen});
      if (word == ECALL_WORD || word == EBREAK_WORD) finish_seen = 1'b1;
      e.instr = word;
      e.pc    = addr;
      e.fin   = finish_seen;
      exp_q.push_back(e);
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
      check("valid_after_rvalid", {31'b0, instr_valid}, 32'd1);
      if (hold_mode == 2) return;
      pc = addr + 32'd4;
      pc_valid = 1'b1;
      repeat (rdy_dly) begin
         tick();
         check("valid_under_backpressure", {31'b0, instr_valid}, 32'd1);
         check("no_req_in_hold", {31'b0, imem_req}, 32'd0);
      end
      pc_valid = 1'b0;
      if (hold_mode == 1) begin
         flush = 1'b1;
         instr_ready = 1'($urandom_range(0, 1));
      end else begin
         instr_ready = 1'b1;
      end
      tick();
      flush = 1'b0;
      instr_ready = 1'b0;
      check("valid_released", {31'b0, instr_valid}, 32'd0);
   endtask

   // Called at a negedge; asserts reset between clock edges.
   task automatic async_reset();
      pc_valid = 1'b0;
      flush = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      instr_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_finish_flag", {31'b0, finish_flag}, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      finish_seen = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] w;
      int          rv;
      vectors     = 0;
      miscompares = 0;
      finish_seen = 1'b0;
      reset       = 1'b1;
      pc          = '0;
      pc_valid    = 1'b0;
      flush       = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_imem_req", {31'b0, imem_req}, 32'd0);
      check("reset_imem_addr", imem_addr, 32'h0);
      check("reset_instr", instr, 32'h0);
      check("reset_instr_pc", instr_pc, 32'h0);
      check("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("reset_finish", {31'b0, finish_flag}, 32'd0);
      check("reset_fault", {31'b0, fault}, 32'd0);
      reset = 1'b0;
      tick();

      // Basic fetch at minimum latency, then backpressure.
      do_fetch(32'h0, 32'h0050_0093, 0, 0, 0, 0);
      do_fetch(32'h4, 32'h0010_0113, 0, 0, 5, 0);

      // Flush while waiting for the response: the word must vanish.
      pc = 32'h10;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      check("flushed_word_dropped", {31'b0, instr_valid}, 32'd0);
      tick();
      check("flushed_word_dropped_2", {31'b0, instr_valid}, 32'd0);
      do_fetch(32'h40, 32'h0030_0193, 1, 1, 0, 0);

      // Flush in REQ without grant: request withdrawn.
      pc = 32'h20;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      check("req_before_flush", {31'b0, imem_req}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("req_withdrawn", {31'b0, imem_req}, 32'd0);
      tick();
      check("req_stays_low", {31'b0, imem_req}, 32'd0);

      // Randomized traffic, including the top address and the latest legal response.
      for (int i = 0; i < 40; i++) begin
         a = $urandom();
         a[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC;
         w = $urandom();
         if (w == ECALL_WORD || w == EBREAK_WORD) w = w ^ 32'h1;
         rv = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
         do_fetch(a, w, int'($urandom_range(0, 3)), rv, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0) ? 1 : 0);
      end
      do_fetch(32'hFFFF_FFFC, 32'h1234_5678, 0, TIMEOUT - 1, 0, 0);

      // ECALL raises finish and blocks further fetches.
      do_fetch(32'h100, ECALL_WORD, 0, 1, 2, 0);
      pc = 32'h104;
      pc_valid = 1'b1;
      repeat (4) begin
         tick();
         check("no_req_after_finish", {31'b0, imem_req}, 32'd0);
      end
      check("finish_sticky", {31'b0, finish_flag}, 32'd1);
      async_reset();

      // EBREAK, then asynchronous reset while the word is held.
      do_fetch(32'h200, EBREAK_WORD, 1, 0, 0, 2);
      tick();
      check("hold_before_reset", {31'b0, instr_valid}, 32'd1);
      async_reset();
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom();
      tick();
      imem_rvalid = 1'b0;
      check("late_rvalid_ignored", {31'b0, instr_valid}, 32'd0);
      check("late_rvalid_no_req", {31'b0, imem_req}, 32'd0);
      tick();
      check("late_rvalid_ignored_2", {31'b0, instr_valid}, 32'd0);

      // Misaligned PC.
      pc = 32'h6;
      pc_valid = 1'b1;
      tick();
      check("misalign_fault", {31'b0, fault}, 32'd1);
      check("misalign_no_req", {31'b0, imem_req}, 32'd0);
      pc = 32'h8;
      tick();
      check("fault_blocks_fetch", {31'b0, imem_req}, 32'd0);
      async_reset();

      // Response timeout.
      pc = 32'h300;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
      check("to_req", {31'b0, imem_req}, 32'd1);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      repeat (TIMEOUT - 1) tick();
      check("to_no_fault_yet", {31'b0, fault}, 32'd0);
      tick();
      check("to_fault", {31'b0, fault}, 32'd1);
      check("to_no_valid", {31'b0, instr_valid}, 32'd0);
      check("to_no_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hCAFE_F00D;
      tick();
      imem_rvalid = 1'b0;
      check("to_late_rvalid_ignored", {31'b0, instr_valid}, 32'd0);
      async_reset();

      tick();
      tick();
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
